sram_pair_sched: RTL and testbench

Request scheduler sitting directly upstream of the two-instance SRAM hash group (`sram_2inst`). It accepts two independent request lanes (a, b), buffers each lane in a 2-entry FIFO, and resolves bank conflicts when both lane heads target the same SRAM instance (`dest_ram_id[0]`). It drives conflict-free `read_*`/`write_*` commands into the hash group and returns the read data to the originating lane with a response valid.

---
 rtl/vector_cache_pkg.sv | 32 +++
 rtl/sram_sched_fifo2.sv | 49 ++++
 rtl/sram_pair_sched.sv | 188 ++++++++++++++++++
 tb/tb_sram_pair_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_cache_pkg.sv
// vector_cache_pkg: shared types for the vector cache SRAM path, including the
// request format used by the two-lane scheduler in front of sram_2inst.
package vector_cache_pkg;

  localparam int SRAM_ADDR_W = 10;

  // Command presented to one instance port of the sram_2inst hash group.
  typedef struct packed {
    logic [1:0]             dest_ram_id;
    logic [SRAM_ADDR_W-1:0] addr;
  } sram_inst_cmd_t;

  localparam logic SCHED_OP_RD = 1'b0;
  localparam logic SCHED_OP_WR = 1'b1;

  // One scheduler request as presented on a lane.
  typedef struct packed {
    logic           op;
    sram_inst_cmd_t cmd;
    logic [31:0]    wdata;
  } sched_req_t;

  // All-zero command that only steers the bank bit; used on idle output lanes
  // so the hash group never sees both lanes pointing at the same instance.
  function automatic sram_inst_cmd_t sched_idle_cmd(input logic bank);
    sram_inst_cmd_t c;
    c                = '0;
    c.dest_ram_id[0] = bank;
    return c;
  endfunction

endpackage

// File: rtl/sram_sched_fifo2.sv
// sram_sched_fifo2: two-entry request buffer for one scheduler lane.
// The caller gates push with not_full and pop with head_vld.
module sram_sched_fifo2
  import vector_cache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  sched_req_t din,
  input  logic       pop,
  output logic       head_vld,
  output sched_req_t head,
  output logic       not_full
);

  sched_req_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;

  assign head_vld = (cnt != 2'd0);
  assign not_full = (cnt != 2'(DEPTH));
  assign head     = mem[rd_ptr];

  // Pointers and occupancy; push and pop in the same cycle leave cnt unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are meaningless while cnt says the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_pair_sched.sv
// sram_pair_sched: two-lane request scheduler feeding the sram_2inst hash group.
// Buffers each lane, resolves same-bank conflicts round-robin, drives registered
// read/write commands and returns read data to the originating lane.
// Optional feature: define SRAM_SCHED_CONFLICT_CNT_EN to build the saturating
// conflict counter; otherwise conflict_cnt is tied to zero.
module sram_pair_sched
  import vector_cache_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int RD_LAT     = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_vld_a,
  output logic           req_rdy_a,
  input  sched_req_t     req_a,
  input  logic           req_vld_b,
  output logic           req_rdy_b,
  input  sched_req_t     req_b,
  output logic           read_vld_a,
  output logic           write_vld_a,
  output sram_inst_cmd_t read_cmd_a,
  output sram_inst_cmd_t write_cmd_a,
  output logic [31:0]    wr_data_a,
  input  logic [31:0]    rd_data_a,
  output logic           read_vld_b,
  output logic           write_vld_b,
  output sram_inst_cmd_t read_cmd_b,
  output sram_inst_cmd_t write_cmd_b,
  output logic [31:0]    wr_data_b,
  input  logic [31:0]    rd_data_b,
  output logic           rsp_vld_a,
  output logic [31:0]    rsp_data_a,
  output logic           rsp_vld_b,
  output logic [31:0]    rsp_data_b,
  output logic [15:0]    conflict_cnt
);

  sched_req_t     head_a_p0, head_b_p0;
  logic           hv_a_p0, hv_b_p0;
  logic           nf_a, nf_b;
  logic           bank_a_p0, bank_b_p0;
  logic           conflict_p0;
  logic           iss_a_p0, iss_b_p0;
  logic           rd_a_p0, wr_a_p0, rd_b_p0, wr_b_p0;
  sram_inst_cmd_t cmd_a_p0, cmd_b_p0;
  logic [31:0]    wdata_a_p0, wdata_b_p0;
  logic           rr_ptr;

  logic           rd_vld_a_p1, wr_vld_a_p1, rd_vld_b_p1, wr_vld_b_p1;
  sram_inst_cmd_t cmd_a_p1, cmd_b_p1;
  logic [31:0]    wdata_a_p1, wdata_b_p1;

  logic [RD_LAT-1:0] rvld_a_p2, rvld_b_p2;

  // ---- stage p0: lane buffers, ready from pre-pop occupancy ----
  assign req_rdy_a = nf_a & ~rst;
  assign req_rdy_b = nf_b & ~rst;

  sram_sched_fifo2 #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .push     (req_vld_a & req_rdy_a),
    .din      (req_a),
    .pop      (iss_a_p0),
    .head_vld (hv_a_p0),
    .head     (head_a_p0),
    .not_full (nf_a)
  );

  sram_sched_fifo2 #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .push     (req_vld_b & req_rdy_b),
    .din      (req_b),
    .pop      (iss_b_p0),
    .head_vld (hv_b_p0),
    .head     (head_b_p0),
    .not_full (nf_b)
  );

  // Arbitration on the lane heads and next-cycle command selection, with the
  // idle lane steered to the opposite bank of the busy one.
  always_comb begin
    bank_a_p0   = head_a_p0.cmd.dest_ram_id[0];
    bank_b_p0   = head_b_p0.cmd.dest_ram_id[0];
    conflict_p0 = hv_a_p0 && hv_b_p0 && (bank_a_p0 == bank_b_p0);
    iss_a_p0    = hv_a_p0 && (!conflict_p0 || !rr_ptr);
    iss_b_p0    = hv_b_p0 && (!conflict_p0 || rr_ptr);
    rd_a_p0     = iss_a_p0 && (head_a_p0.op == SCHED_OP_RD);
    wr_a_p0     = iss_a_p0 && (head_a_p0.op == SCHED_OP_WR);
    rd_b_p0     = iss_b_p0 && (head_b_p0.op == SCHED_OP_RD);
    wr_b_p0     = iss_b_p0 && (head_b_p0.op == SCHED_OP_WR);
    cmd_a_p0    = sched_idle_cmd(1'b1);
    cmd_b_p0    = sched_idle_cmd(1'b0);
    wdata_a_p0  = '0;
    wdata_b_p0  = '0;
    if (iss_a_p0) begin
      cmd_a_p0   = head_a_p0.cmd;
      wdata_a_p0 = head_a_p0.wdata;
      cmd_b_p0   = sched_idle_cmd(!bank_a_p0);
    end
    if (iss_b_p0) begin
      cmd_b_p0   = head_b_p0.cmd;
      wdata_b_p0 = head_b_p0.wdata;
      if (!iss_a_p0) cmd_a_p0 = sched_idle_cmd(!bank_b_p0);
    end
  end

  // Round-robin pointer: the loser of a conflict wins the next one.
  always_ff @(posedge clk) begin
    if (rst)              rr_ptr <= 1'b0;
    else if (conflict_p0) rr_ptr <= ~rr_ptr;
  end

  // ---- stage p1: registered hash-group command ports ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_a_p1 <= 1'b0;
      wr_vld_a_p1 <= 1'b0;
      rd_vld_b_p1 <= 1'b0;
      wr_vld_b_p1 <= 1'b0;
      cmd_a_p1    <= sched_idle_cmd(1'b1);
      cmd_b_p1    <= sched_idle_cmd(1'b0);
      wdata_a_p1  <= '0;
      wdata_b_p1  <= '0;
    end else begin
      rd_vld_a_p1 <= rd_a_p0;
      wr_vld_a_p1 <= wr_a_p0;
      rd_vld_b_p1 <= rd_b_p0;
      wr_vld_b_p1 <= wr_b_p0;
      cmd_a_p1    <= cmd_a_p0;
      cmd_b_p1    <= cmd_b_p0;
      wdata_a_p1  <= wdata_a_p0;
      wdata_b_p1  <= wdata_b_p0;
    end
  end

  assign read_vld_a  = rd_vld_a_p1 & ~rst;
  assign write_vld_a = wr_vld_a_p1 & ~rst;
  assign read_vld_b  = rd_vld_b_p1 & ~rst;
  assign write_vld_b = wr_vld_b_p1 & ~rst;
  assign read_cmd_a  = cmd_a_p1;
  assign write_cmd_a = cmd_a_p1;
  assign read_cmd_b  = cmd_b_p1;
  assign write_cmd_b = cmd_b_p1;
  assign wr_data_a   = wdata_a_p1;
  assign wr_data_b   = wdata_b_p1;

  // ---- stage p2: read-valid delay line matching the hash-group latency ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rvld_a_p2 <= '0;
      rvld_b_p2 <= '0;
    end else begin
      rvld_a_p2[0] <= rd_vld_a_p1;
      rvld_b_p2[0] <= rd_vld_b_p1;
      for (int i = 1; i < RD_LAT; i++) begin
        rvld_a_p2[i] <= rvld_a_p2[i-1];
        rvld_b_p2[i] <= rvld_b_p2[i-1];
      end
    end
  end

  assign rsp_vld_a  = rvld_a_p2[RD_LAT-1] & ~rst;
  assign rsp_vld_b  = rvld_b_p2[RD_LAT-1] & ~rst;
  assign rsp_data_a = rd_data_a;
  assign rsp_data_b = rd_data_b;

`ifdef SRAM_SCHED_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating count of same-bank conflicts seen by the arbiter.
  always_ff @(posedge clk) begin
    if (rst)              conflict_cnt_q <= '0;
    else if (conflict_p0) conflict_cnt_q <= sat_inc16(conflict_cnt_q);
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_pair_sched.sv
// tb_sram_pair_sched: scoreboard bench for sram_pair_sched. Accepted requests are
// queued per lane and matched against issued commands; reads queue an expected
// response that is matched when rsp_vld rises.
module tb_sram_pair_sched;
  import vector_cache_pkg::*;

  localparam int RD_LAT = 1;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_vld_a, req_rdy_a, req_vld_b, req_rdy_b;
  sched_req_t     req_a, req_b;
  logic           read_vld_a, write_vld_a, read_vld_b, write_vld_b;
  sram_inst_cmd_t read_cmd_a, write_cmd_a, read_cmd_b, write_cmd_b;
  logic [31:0]    wr_data_a, wr_data_b, rd_data_a, rd_data_b;
  logic           rsp_vld_a, rsp_vld_b;
  logic [31:0]    rsp_data_a, rsp_data_b;
  logic [15:0]    conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit gaps  = 1'b0;

  sched_req_t exp_q  [2][$];
  rsp_t       rsp_q  [2][$];
  sched_req_t pend_a [$];
  sched_req_t pend_b [$];
  bit         iss_lane  [$];
  int         iss_cyc_a [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data_a = {16'hA5A5, cyc[15:0]};
  assign rd_data_b = {16'h5A5A, cyc[15:0]};

  sram_pair_sched #(.FIFO_DEPTH(2), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_vld_a(req_vld_a), .req_rdy_a(req_rdy_a), .req_a(req_a),
    .req_vld_b(req_vld_b), .req_rdy_b(req_rdy_b), .req_b(req_b),
    .read_vld_a(read_vld_a), .write_vld_a(write_vld_a),
    .read_cmd_a(read_cmd_a), .write_cmd_a(write_cmd_a),
    .wr_data_a(wr_data_a), .rd_data_a(rd_data_a),
    .read_vld_b(read_vld_b), .write_vld_b(write_vld_b),
    .read_cmd_b(read_cmd_b), .write_cmd_b(write_cmd_b),
    .wr_data_b(wr_data_b), .rd_data_b(rd_data_b),
    .rsp_vld_a(rsp_vld_a), .rsp_data_a(rsp_data_a),
    .rsp_vld_b(rsp_vld_b), .rsp_data_b(rsp_data_b),
    .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic sched_req_t mk(input logic op, input logic [1:0] dest,
                                    input logic [9:0] addr, input logic [31:0] wd);
    sched_req_t r;
    r.op              = op;
    r.cmd.dest_ram_id = dest;
    r.cmd.addr        = addr;
    r.wdata           = wd;
    return r;
  endfunction

  function automatic sram_inst_cmd_t idle_exp(input logic b);
    sram_inst_cmd_t c;
    c = '0;
    c.dest_ram_id[0] = b;
    return c;
  endfunction

  task automatic mon_lane(input bit l, input logic rv, input logic wv,
                          input sram_inst_cmd_t rc, input sram_inst_cmd_t wc,
                          input logic [31:0] wd, input logic rspv, input logic [31:0] rspd);
    sched_req_t e;
    rsp_t       r;
    string      nm = l ? "b" : "a";
    if (rv || wv) begin
      if (exp_q[l].size() == 0) check({"unexpected_issue_", nm}, 1, 0);
      else begin
        e = exp_q[l].pop_front();
        check({"issue_kind_", nm}, {rv, wv}, (e.op == SCHED_OP_WR) ? 2'b01 : 2'b10);
        check({"read_cmd_", nm}, rc, e.cmd);
        check({"write_cmd_", nm}, wc, e.cmd);
        check({"wr_data_", nm}, wd, e.wdata);
        if (e.op == SCHED_OP_RD) begin
          r.due = cyc + RD_LAT;
          r.d   = {(l ? 16'h5A5A : 16'hA5A5), 16'(cyc + RD_LAT)};
          rsp_q[l].push_back(r);
        end
      end
      iss_lane.push_back(l);
      if (!l) iss_cyc_a.push_back(cyc);
    end
    if (rspv) begin
      if (rsp_q[l].size() == 0) check({"unexpected_rsp_", nm}, 1, 0);
      else begin
        r = rsp_q[l].pop_front();
        check({"rsp_cycle_", nm}, 64'(cyc), 64'(r.due));
        check({"rsp_data_", nm}, rspd, r.d);
      end
    end else if (rsp_q[l].size() > 0 && rsp_q[l][0].due <= cyc) begin
      check({"missing_rsp_", nm}, 0, 1);
      void'(rsp_q[l].pop_front());
    end
  endtask

  // Per-cycle scoreboard and hash-group bank-separation monitor.
  always @(negedge clk) begin
    mon_lane(1'b0, read_vld_a, write_vld_a, read_cmd_a, write_cmd_a, wr_data_a, rsp_vld_a, rsp_data_a);
    mon_lane(1'b1, read_vld_b, write_vld_b, read_cmd_b, write_cmd_b, wr_data_b, rsp_vld_b, rsp_data_b);
    if (!rst) begin
      check("rd_bank_sep", read_cmd_a.dest_ram_id[0] ^ read_cmd_b.dest_ram_id[0], 1);
      check("wr_bank_sep", write_cmd_a.dest_ram_id[0] ^ write_cmd_b.dest_ram_id[0], 1);
      if (!(read_vld_a || write_vld_a))
        check("idle_cmd_a", {read_cmd_a, write_cmd_a},
              {2{idle_exp((read_vld_b || write_vld_b) ? ~read_cmd_b.dest_ram_id[0] : 1'b1)}});
      if (!(read_vld_b || write_vld_b))
        check("idle_cmd_b", {read_cmd_b, write_cmd_b},
              {2{idle_exp((read_vld_a || write_vld_a) ? ~read_cmd_a.dest_ram_id[0] : 1'b0)}});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_vld_a = 1'b0;
    req_vld_b = 1'b0;
  endtask

  task automatic flush();
    for (int l = 0; l < 2; l++) begin
      exp_q[l].delete();
      rsp_q[l].delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    flush();
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Drive one cycle of requests; acceptance is recorded mid-cycle.
  task automatic offer(input logic va, input sched_req_t ra, input logic vb, input sched_req_t rb);
    req_vld_a = va; req_a = ra;
    req_vld_b = vb; req_b = rb;
    @(negedge clk);
    if (req_vld_a && req_rdy_a) exp_q[0].push_back(req_a);
    if (req_vld_b && req_rdy_b) exp_q[1].push_back(req_b);
  endtask

  task automatic pump(input int max_cyc);
    int n = 0;
    while ((pend_a.size() > 0 || pend_b.size() > 0) && n < max_cyc) begin
      req_vld_a = (pend_a.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      req_vld_b = (pend_b.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      if (pend_a.size() > 0) req_a = pend_a[0];
      if (pend_b.size() > 0) req_b = pend_b[0];
      @(negedge clk);
      if (req_vld_a && req_rdy_a) exp_q[0].push_back(pend_a.pop_front());
      if (req_vld_b && req_rdy_b) exp_q[1].push_back(pend_b.pop_front());
      step();
      n++;
    end
    idle_in();
    check("pump_done", n < max_cyc, 1);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + rsp_q[0].size() + rsp_q[1].size()) > 0
           && n < max_cyc) begin
      step();
      n++;
    end
    step();
    check("drain_done", n < max_cyc, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [15:0] exp_conf;
    rst = 1'b1;
    idle_in();
    req_a = '0;
    req_b = '0;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check("rst_rdy", {req_rdy_a, req_rdy_b}, 0);
    check("rst_vld", {read_vld_a, write_vld_a, read_vld_b, write_vld_b, rsp_vld_a, rsp_vld_b}, 0);
    check("rst_cmd_a", {read_cmd_a, write_cmd_a}, {2{idle_exp(1'b1)}});
    check("rst_cmd_b", {read_cmd_b, write_cmd_b}, {2{idle_exp(1'b0)}});
    check("rst_wr_data", {wr_data_a, wr_data_b}, 0);
    check("rst_conflict_cnt", conflict_cnt, 0);
    step();
    do_reset();

    // Different banks: both lanes issue together, reads return
    offer(1, mk(SCHED_OP_RD, 2'd1, 10'h011, 32'h0), 1, mk(SCHED_OP_RD, 2'd0, 10'h022, 32'h0));
    step();
    idle_in();
    @(negedge clk);
    check("t1_no_issue_c1", {read_vld_a, read_vld_b}, 0);
    step();
    @(negedge clk);
    check("t1_both_read_c2", {read_vld_a, write_vld_a, read_vld_b, write_vld_b}, 4'b1010);
    step();
    @(negedge clk);
    check("t1_rsp_vld_c3", {rsp_vld_a, rsp_vld_b}, 2'b11);
    check("t1_rsp_data_a", rsp_data_a, {16'hA5A5, 16'(cyc)});
    check("t1_conflict_cnt", conflict_cnt, 0);
    drain(20);

    // Same bank writes: a first, b one cycle later
    do_reset();
    offer(1, mk(SCHED_OP_WR, 2'd0, 10'h100, 32'h1111_0000), 1, mk(SCHED_OP_WR, 2'd2, 10'h200, 32'h2222_0000));
    step();
    idle_in();
    step();
    @(negedge clk);
    check("t2_c2_lanes", {write_vld_a, write_vld_b}, 2'b10);
    step();
    @(negedge clk);
    check("t2_c3_lanes", {write_vld_a, write_vld_b}, 2'b01);
`ifdef SRAM_SCHED_CONFLICT_CNT_EN
    exp_conf = 16'd1;
`else
    exp_conf = 16'd0;
`endif
    check("t2_conflict_cnt", conflict_cnt, exp_conf);
    check("t2_rr_ptr", dut.rr_ptr, 1);
    drain(20);

    // Lane a idle, lane b reads bank 1
    do_reset();
    offer(0, '0, 1, mk(SCHED_OP_RD, 2'd1, 10'h055, 32'h0));
    step();
    idle_in();
    step();
    @(negedge clk);
    check("t3_b_read", read_vld_b, 1);
    check("t3_a_vld_low", {read_vld_a, write_vld_a}, 0);
    check("t3_a_idle_cmd", {read_cmd_a, write_cmd_a}, {2{idle_exp(1'b0)}});
    drain(20);

    // Four back-to-back requests on lane a
    do_reset();
    iss_cyc_a.delete();
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      offer(1, mk(i[0] ? SCHED_OP_WR : SCHED_OP_RD, 2'(i), 10'(i + 7), 32'hC0DE_0000 + i), 0, '0);
      check("t4_rdy_a", req_rdy_a, 1);
      step();
    end
    idle_in();
    drain(20);
    check("t4_issue_count", iss_cyc_a.size(), 4);
    for (int i = 0; i < 4; i++) check("t4_issue_cycle", iss_cyc_a[i], base + 2 + i);

    // Continuous same-bank traffic: strict alternation
    do_reset();
    iss_lane.delete();
    gaps = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pend_a.push_back(mk(i[0], 2'd0, 10'(i), 32'hAA00_0000 + i));
      pend_b.push_back(mk(~i[0], 2'd2, 10'(i + 100), 32'hBB00_0000 + i));
    end
    pump(200);
    drain(100);
    check("t5_issue_count", iss_lane.size(), 20);
    for (int i = 0; i < 20; i++) check("t5_alternation", iss_lane[i], i % 2);
`ifdef SRAM_SCHED_CONFLICT_CNT_EN
    exp_conf = 16'd19;
`else
    exp_conf = 16'd0;
`endif
    check("t5_conflict_cnt", conflict_cnt, exp_conf);

    // Random traffic with gaps; monitor keeps checking bank separation
    do_reset();
    gaps = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pend_a.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10'($urandom), $urandom));
      pend_b.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10'($urandom), $urandom));
    end
    pump(3000);
    drain(100);
    gaps = 1'b0;

    // Reset one cycle after a read issues
    do_reset();
    offer(1, mk(SCHED_OP_RD, 2'd0, 10'h301, 32'h0), 0, '0);
    step();
    offer(1, mk(SCHED_OP_RD, 2'd0, 10'h302, 32'h0), 0, '0);
    step();
    offer(1, mk(SCHED_OP_WR, 2'd1, 10'h303, 32'h3333_0000), 1, mk(SCHED_OP_WR, 2'd1, 10'h304, 32'h4444_0000));
    check("t6_read_issued", read_vld_a, 1);
    step();
    rst = 1'b1;
    idle_in();
    flush();
    @(negedge clk);
    check("t6_no_rsp", {rsp_vld_a, rsp_vld_b}, 0);
    check("t6_vld_low", {read_vld_a, write_vld_a, read_vld_b, write_vld_b}, 0);
    step();
    step();
    @(negedge clk);
    check("t6_rst_rdy", {req_rdy_a, req_rdy_b}, 0);
    check("t6_rst_cmd", {read_cmd_a, read_cmd_b}, {idle_exp(1'b1), idle_exp(1'b0)});
    check("t6_rst_wr_data", {wr_data_a, wr_data_b}, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_issue", {read_vld_a, write_vld_a, read_vld_b, write_vld_b, rsp_vld_a, rsp_vld_b}, 0);
      check("t6_fifo_empty", {dut.u_fifo_a.head_vld, dut.u_fifo_b.head_vld}, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
